// File: rtl/row_map_table_dbuf.sv
// Double-buffered row address remap table: N_CH lookups per cycle from the active bank,
// shadow bank loaded through a valid/ready port, bank swap deferred to a frame boundary.
module row_map_table_dbuf #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int N_CH   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*ADDR_W-1:0]   rowadd_in,
   output logic [N_CH*ADDR_W-1:0]   rowadd_out,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [ADDR_W-1:0]        wr_data,
   input  logic                     commit,
   input  logic                     frame_sync,
   output logic                     commit_pending,
   output logic                     active_bank,
   output logic                     busy,
   output logic                     wr_err
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_COPY} state_t;

   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   idx, idx_next;
   logic [ADDR_W-1:0]   bank0 [DEPTH];
   logic [ADDR_W-1:0]   bank1 [DEPTH];

   logic                bank0_we, bank1_we;
   logic [ADDR_W-1:0]   bank0_addr, bank1_addr, bank0_data, bank1_data;
   logic [N_CH*ADDR_W-1:0] lookup_next;

   logic wr_fire, wr_in_range, swap, idx_done;

   assign wr_fire     = wr_valid && wr_ready;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
   assign swap        = (state == S_IDLE) && (commit_pending || commit) && frame_sync;
   assign idx_done    = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INIT;
         idx   <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         S_INIT, S_COPY: begin
            idx_next = idx + 1'b1;
            if (idx_done) begin
               state_next = S_IDLE;
               idx_next   = '0;
            end
         end
         S_IDLE: begin
            if (swap) begin
               state_next = S_COPY;
               idx_next   = '0;
            end
         end
         default: begin
            state_next = S_INIT;
            idx_next   = '0;
         end
      endcase
   end

   // During COPY active_bank already points at the new active bank, so the
   // opposite bank is the one being overwritten.
   always_comb begin
      busy       = (state != S_IDLE);
      wr_ready   = (state == S_IDLE);
      bank0_we   = 1'b0;
      bank1_we   = 1'b0;
      bank0_addr = idx;
      bank1_addr = idx;
      bank0_data = idx;
      bank1_data = idx;
      case (state)
         S_INIT: begin
            bank0_we = 1'b1;
            bank1_we = 1'b1;
         end
         S_IDLE: begin
            if (wr_fire && wr_in_range) begin
               bank0_we   = active_bank;
               bank1_we   = ~active_bank;
               bank0_addr = wr_addr;
               bank1_addr = wr_addr;
               bank0_data = wr_data;
               bank1_data = wr_data;
            end
         end
         S_COPY: begin
            bank0_we   = active_bank;
            bank1_we   = ~active_bank;
            bank0_data = bank1[idx];
            bank1_data = bank0[idx];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && bank0_we) bank0[bank0_addr] <= bank0_data;
      if (!rst && bank1_we) bank1[bank1_addr] <= bank1_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_bank    <= 1'b0;
         commit_pending <= 1'b0;
         wr_err         <= 1'b0;
      end else begin
         if (swap) active_bank <= ~active_bank;
         commit_pending <= swap ? 1'b0 : (commit_pending | commit);
         if (wr_fire && !wr_in_range) wr_err <= 1'b1;
      end
   end

   // Tables are only trustworthy once INIT completes, so INIT forces identity.
   always_comb begin
      lookup_next = rowadd_in;
      for (int c = 0; c < N_CH; c++) begin
         if (state != S_INIT && ({1'b0, rowadd_in[c*ADDR_W +: ADDR_W]} < DEPTH_EXT)) begin
            lookup_next[c*ADDR_W +: ADDR_W] = active_bank ? bank1[rowadd_in[c*ADDR_W +: ADDR_W]]
                                                          : bank0[rowadd_in[c*ADDR_W +: ADDR_W]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rowadd_out <= '0;
      else     rowadd_out <= lookup_next;
   end

endmodule

// File: doc/row_map_table_dbuf.md
Name: row_map_table_dbuf

Overview:
Parametrised, double-buffered successor to the row address remap LUT. It serves N_CH independent row-address lookups per cycle from an active bank. Software or an FSM loads a shadow bank through a valid/ready port. A commit request swaps the banks at the next frame boundary, so a readout never sees a half-written map. It sits between the row sequencer and the per-ADC row address buses.

Parameters:
ADDR_W, 9, row address width (input, output and table entry width)
DEPTH, 512, number of table entries; must satisfy DEPTH <= 2**ADDR_W
N_CH, 2, number of parallel lookup channels sharing the active bank

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
rowadd_in  in  N_CH*ADDR_W  channel c occupies bits [c*ADDR_W +: ADDR_W]
rowadd_out  out  N_CH*ADDR_W  registered mapped row address per channel
wr_valid  in  1  shadow-bank write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  shadow entry index
wr_data  in  ADDR_W  shadow entry value
commit  in  1  single-cycle pulse requesting a bank swap
frame_sync  in  1  single-cycle frame boundary pulse; swaps happen only here
commit_pending  out  1  commit latched, swap not yet done
active_bank  out  1  index of the bank currently serving lookups
busy  out  1  init or copy in progress
wr_err  out  1  sticky flag: out-of-range write dropped

Behaviour:
- Storage: two banks of DEPTH x ADDR_W with asynchronous read (distributed RAM). Writes are synchronous.
- Reset values: rowadd_out=0, wr_ready=0, commit_pending=0, active_bank=0, wr_err=0, busy=1. The FSM enters S_INIT with index=0.
- FSM states: S_INIT, S_IDLE, S_COPY.
- S_INIT: writes bank0[i]=bank1[i]=i for i=0..DEPTH-1, one entry per cycle, over DEPTH cycles. It then moves to S_IDLE. busy=1 for exactly DEPTH cycles after rst is released.
- S_IDLE: busy=0 and wr_ready=1. On an accepted write with wr_addr<DEPTH, shadow[wr_addr]<=wr_data. If wr_addr>=DEPTH, the write is dropped and wr_err is set; wr_err clears only on rst.
- Commit latch: a commit pulse sets commit_pending. The latch works in every state, including S_INIT and S_COPY. Repeat commits while pending have no extra effect.
- Swap: happens in S_IDLE on the cycle where (commit_pending || commit) && frame_sync. Effects of the swap:
  - active_bank toggles and commit_pending clears.
  - The FSM enters S_COPY.
  - A write accepted in the same cycle lands in the old shadow bank, so it is included in the new active map.
- S_COPY: copies new-active[i] into new-shadow[i] for i=0..DEPTH-1 over DEPTH cycles, so shadow starts equal to active. busy=1 and wr_ready=0 throughout. frame_sync is ignored for swaps; commit still latches. Returns to S_IDLE.
- Lookup: rowadd_out[c] <= table[active_bank][rowadd_in[c]], one-cycle latency, valid in every state.
  - In S_INIT the output is identity (rowadd_in passes through).
  - If rowadd_in[c]>=DEPTH, the input passes through unchanged.
  - A lookup sampled on the swap edge uses the old bank. The first lookup using the new bank is the one registered on the edge after the swap.
- A commit with no frame_sync keeps commit_pending=1 indefinitely and the active map does not change.
- Asserting rst during S_COPY or S_IDLE aborts the operation. The block re-enters S_INIT next cycle with all reset values, and both banks are re-filled with identity.

Test Plan:
- Reset, then release rst. Require busy=1 for 512 cycles, then busy=0 and wr_ready=1. Drive rowadd_in ch0=17, ch1=240 -> rowadd_out ch0=17, ch1=240 one cycle later.
- Write shadow[a]=a+1 for a=0..240, then pulse commit. Require no output change and commit_pending=1. Pulse frame_sync -> active_bank=1, commit_pending=0, busy=1 for 512 cycles. Lookup 5 -> 6 and 240 -> 241.
- Write to wr_addr=511 with DEPTH=480 -> entry dropped, wr_err=1 and stays 1. Other entries unchanged.
- Pulse commit and frame_sync in the same cycle, with a write (addr 3, data 100) accepted in that cycle -> swap occurs and lookup 3 -> 100. A lookup sampled on the swap edge returns the old value.
- During S_COPY, pulse commit and frame_sync -> no swap and commit_pending=1. The swap happens on the first frame_sync after busy falls.
- Assert rst mid-copy (cycle 200 of 512) -> active_bank=0, commit_pending=0, busy=1 for 512 cycles, identity map restored.
